// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states and instruction layout.
package alu_pkg;

    localparam int unsigned INSTR_W = 10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    localparam logic [3:0] DIV0_FILL = 4'hF;

    // Instruction field positions
    localparam int unsigned LDI_BIT = 9;
    localparam int unsigned RSV_BIT = 8;
    localparam int unsigned OP_MSB  = 7;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS1_MSB = 3;
    localparam int unsigned RS1_LSB = 2;
    localparam int unsigned RS2_MSB = 1;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StExec  = 2'd2,
        StWb    = 2'd3
    } issue_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports plus a debug read, one synchronous write port.
module alu_regfile #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREGS  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [DATA_W-1:0]        rdata1,
    output logic [DATA_W-1:0]        rdata2,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1   = regs_q[raddr1];
    assign rdata2   = regs_q[raddr2];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues instructions to the external 4-bit ALU: operand fetch, ALU handshake and writeback.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned NREGS   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_W-1:0]       instr,
    output logic                     alu_enable,
    output logic [1:0]               alu_op,
    output logic [DATA_W-1:0]        alu_n1,
    output logic [DATA_W-1:0]        alu_n2,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     result_valid,
    output logic [$clog2(NREGS)-1:0] result_rd,
    output logic [DATA_W-1:0]        result_data,
    output logic                     div0_err,
    input  logic                     err_clr,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    issue_state_e      state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [DATA_W-1:0] n1_q, n1_d;
    logic [DATA_W-1:0] n2_q, n2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              div0_q, div0_d;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;

    logic              is_ldi;
    logic [1:0]        f_op;
    logic [AW-1:0]     f_rd, f_rs1, f_rs2;
    logic [DATA_W-1:0] f_imm;
    logic              unused_rsvd;

    assign is_ldi      = instr[LDI_BIT];
    assign f_op        = instr[OP_MSB:OP_LSB];
    assign f_rd        = instr[RD_MSB:RD_LSB];
    assign f_rs1       = instr[RS1_MSB:RS1_LSB];
    assign f_rs2       = instr[RS2_MSB:RS2_LSB];
    assign f_imm       = instr[IMM_MSB:IMM_LSB];
    assign unused_rsvd = instr[RSV_BIT];

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1   (f_rs1),
        .raddr2   (f_rs2),
        .rdata1   (rf_rdata1),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        n1_d     = n1_q;
        n2_d     = n2_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        div0_d   = div0_q;
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_result;

        // A new divide-by-zero below overrides a simultaneous clear
        if (err_clr) begin
            div0_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    rd_d = f_rd;
                    if (is_ldi) begin
                        rf_we    = 1'b1;
                        rf_waddr = f_rd;
                        rf_wdata = f_imm;
                        res_d    = f_imm;
                        state_d  = StWb;
                    end else if (f_op == ALU_DIV && rf_rdata2 == '0) begin
                        rf_we    = 1'b1;
                        rf_waddr = f_rd;
                        rf_wdata = DATA_W'(DIV0_FILL);
                        res_d    = DATA_W'(DIV0_FILL);
                        div0_d   = 1'b1;
                        state_d  = StWb;
                    end else begin
                        op_d    = f_op;
                        n1_d    = rf_rdata1;
                        n2_d    = rf_rdata2;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = CNT_W'(ALU_LAT - 1);
                state_d = StExec;
            end
            StExec: begin
                if (cnt_q == '0) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = alu_result;
                    res_d    = alu_result;
                    state_d  = StWb;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            rd_q    <= '0;
            n1_q    <= '0;
            n2_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            div0_q  <= div0_d;
        end
    end

    // Operands hold the last issued ALU instruction; LDI and div-by-zero never touch them
    assign alu_op       = op_q;
    assign alu_n1       = n1_q;
    assign alu_n2       = n2_q;
    assign alu_enable   = (state_q == StExec);
    assign instr_ready  = (state_q == StIdle);
    assign result_valid = (state_q == StWb);
    assign result_rd    = rd_q;
    assign result_data  = res_q;
    assign div0_err     = div0_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, ALU_LAT=1 and ALU_LAT=3 instances.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [9:0] ins;
        logic       clr;
        logic [3:0] data;
        int         lat;
        int         en;
        logic       div0;
    } row_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [9:0] instr = '0;
    logic       err_clr = 1'b0;
    logic [1:0] dbg_sel = '0;
    logic       sel = 1'b0;

    logic       v1, rdy1, en1, rv1, d0_1;
    logic [1:0] op1, rd1;
    logic [3:0] a1, b1, res1, rdat1, dbg1;
    logic       v3, rdy3, en3, rv3, d0_3;
    logic [1:0] op3, rd3;
    logic [3:0] a3, b3, res3, rdat3, dbg3;

    logic       m_rdy, m_en, m_rv, m_d0;
    logic [1:0] m_op, m_rd;
    logic [3:0] m_a, m_b, m_rdat, m_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == 4'd0) ? 4'hF : a / b;
        endcase
    endfunction

    assign res1 = alu_f(op1, a1, b1);
    assign res3 = alu_f(op3, a3, b3);
    assign v1   = instr_valid & ~sel;
    assign v3   = instr_valid & sel;

    assign m_rdy  = sel ? rdy3 : rdy1;
    assign m_en   = sel ? en3 : en1;
    assign m_rv   = sel ? rv3 : rv1;
    assign m_d0   = sel ? d0_3 : d0_1;
    assign m_op   = sel ? op3 : op1;
    assign m_rd   = sel ? rd3 : rd1;
    assign m_a    = sel ? a3 : a1;
    assign m_b    = sel ? b3 : b1;
    assign m_rdat = sel ? rdat3 : rdat1;
    assign m_dbg  = sel ? dbg3 : dbg1;

    alu_issue_ctrl #(.DATA_W(4), .NREGS(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy1), .instr(instr),
        .alu_enable(en1), .alu_op(op1), .alu_n1(a1), .alu_n2(b1), .alu_result(res1),
        .result_valid(rv1), .result_rd(rd1), .result_data(rdat1), .div0_err(d0_1),
        .err_clr(err_clr), .dbg_sel(dbg_sel), .dbg_data(dbg1)
    );

    alu_issue_ctrl #(.DATA_W(4), .NREGS(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v3), .instr_ready(rdy3), .instr(instr),
        .alu_enable(en3), .alu_op(op3), .alu_n1(a3), .alu_n2(b3), .alu_result(res3),
        .result_valid(rv3), .result_rd(rd3), .result_data(rdat3), .div0_err(d0_3),
        .err_clr(err_clr), .dbg_sel(dbg_sel), .dbg_data(dbg3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one instruction on the selected instance and follow it to writeback
    task automatic apply_row(input row_t r, input string tag);
        int   lat;
        int   en;
        int   k;
        logic unstable;
        logic [9:0] snap;
        @(negedge clk);
        dbg_sel     = r.ins[5:4];
        instr       = r.ins;
        err_clr     = r.clr;
        instr_valid = 1'b1;
        k = 0;
        while (!m_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        err_clr     = 1'b0;
        lat = 1;
        en  = 0;
        unstable = 1'b0;
        snap = '0;
        @(negedge clk);
        while (!m_rv && lat < 20) begin
            if (m_en) begin
                if (en == 0) snap = {m_op, m_a, m_b};
                else if (snap != {m_op, m_a, m_b}) unstable = 1'b1;
                en++;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, r.lat);
        check({tag, " enable cycles"}, en, r.en);
        check({tag, " operands stable"}, unstable, 0);
        check({tag, " result_rd"}, m_rd, r.ins[5:4]);
        check({tag, " result_data"}, m_rdat, r.data);
        check({tag, " dbg_data"}, m_dbg, r.data);
        check({tag, " div0_err"}, m_d0, r.div0);
        @(negedge clk);
        check({tag, " result_valid one cycle"}, m_rv, 0);
    endtask

    row_t t1[14];
    row_t t3[5];

    initial begin
        int acc;
        int first_acc;
        int last_acc;
        int pulses;
        int busy;

        //      ins                  clr   data   lat en div0
        t1[0]  = '{10'b1_0_00_00_0101, 1'b0, 4'h5, 1, 0, 1'b0}; // LDI r0=5
        t1[1]  = '{10'b1_0_00_01_0011, 1'b0, 4'h3, 1, 0, 1'b0}; // LDI r1=3
        t1[2]  = '{10'b0_0_00_10_00_01, 1'b0, 4'h8, 3, 1, 1'b0}; // ADD r2=r0+r1
        t1[3]  = '{10'b1_0_00_00_0010, 1'b0, 4'h2, 1, 0, 1'b0}; // LDI r0=2
        t1[4]  = '{10'b0_0_01_11_00_01, 1'b0, 4'hF, 3, 1, 1'b0}; // SUB r3=r0-r1
        t1[5]  = '{10'b1_0_00_01_0111, 1'b0, 4'h7, 1, 0, 1'b0}; // LDI r1=7
        t1[6]  = '{10'b0_0_10_11_01_01, 1'b0, 4'h1, 3, 1, 1'b0}; // MUL r3=r1*r1
        t1[7]  = '{10'b1_0_00_01_0000, 1'b0, 4'h0, 1, 0, 1'b0}; // LDI r1=0
        t1[8]  = '{10'b0_0_11_10_00_01, 1'b0, 4'hF, 1, 0, 1'b1}; // DIV r2=r0/r1 (div0)
        t1[9]  = '{10'b0_0_11_11_00_01, 1'b1, 4'hF, 1, 0, 1'b1}; // DIV div0 + err_clr
        t1[10] = '{10'b1_0_00_00_0110, 1'b0, 4'h6, 1, 0, 1'b1}; // LDI r0=6
        t1[11] = '{10'b0_0_00_00_00_00, 1'b0, 4'hC, 3, 1, 1'b1}; // ADD r0=r0+r0
        t1[12] = '{10'b0_1_00_01_00_10, 1'b0, 4'hB, 3, 1, 1'b1}; // ADD r1=r0+r2, rsvd set
        t1[13] = '{10'b0_0_11_01_00_11, 1'b0, 4'h0, 3, 1, 1'b1}; // DIV r1=r0/r3 = 12/15

        t3[0] = '{10'b1_0_00_00_0101, 1'b0, 4'h5, 1, 0, 1'b0};  // LDI r0=5
        t3[1] = '{10'b1_0_00_01_0011, 1'b0, 4'h3, 1, 0, 1'b0};  // LDI r1=3
        t3[2] = '{10'b0_0_00_10_00_01, 1'b0, 4'h8, 5, 3, 1'b0}; // ADD r2=r0+r1
        t3[3] = '{10'b0_0_01_11_01_00, 1'b0, 4'hE, 5, 3, 1'b0}; // SUB r3=r1-r0
        t3[4] = '{10'b0_0_10_00_00_01, 1'b0, 4'hF, 5, 3, 1'b0}; // MUL r0=r0*r1

        // Reset state
        #12;
        check("reset alu_enable", en1, 0);
        check("reset result_valid", rv1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset instr_ready", rdy1, 1);
        check("reset div0_err", d0_1, 0);
        check("reset alu_n1", a1, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check("reset reg", dbg1, 0);
        end

        for (int i = 0; i <= 8; i++) apply_row(t1[i], $sformatf("lat1 row%0d", i));

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr clears div0_err", d0_1, 0);

        for (int i = 9; i < 14; i++) apply_row(t1[i], $sformatf("lat1 row%0d", i));

        // Back-to-back: ADD r0=r0+r0 held valid, r0 = C -> 8 -> 0
        @(negedge clk);
        instr       = 10'b0_0_00_00_00_00;
        dbg_sel     = 2'd0;
        instr_valid = 1'b1;
        acc = 0;
        first_acc = -1;
        last_acc = -1;
        pulses = 0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (rdy1) begin
                acc++;
                if (first_acc < 0) first_acc = i;
                last_acc = i;
            end else begin
                busy++;
            end
            if (rv1) pulses++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b accepts", acc, 2);
        check("b2b throughput", last_acc - first_acc, 4);
        check("b2b ready low cycles", busy, 6);
        check("b2b result pulses", pulses, 2);
        check("b2b r0 final", dbg1, 4'h0);

        // Longer ALU latency instance
        sel = 1'b1;
        for (int i = 0; i < 5; i++) apply_row(t3[i], $sformatf("lat3 row%0d", i));
        sel = 1'b0;

        // Reset while the ALU is enabled
        @(negedge clk);
        instr       = 10'b0_0_00_10_00_01;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset alu_enable", en1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-exec reset alu_enable", en1, 0);
        check("mid-exec reset result_valid", rv1, 0);
        check("mid-exec reset div0_err", d0_1, 0);
        check("mid-exec reset alu_op", op1, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check("mid-exec reset reg", dbg1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rv1) pulses++;
        end
        check("no writeback after reset", pulses, 0);
        check("ready after reset", rdy1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
